// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream engine.
//  - rd_state_e : reader FSM encoding (IDLE / RUN / DRAIN)
//  - DEF_*      : default data width, packet length and packet-counter width
//  - credit_ok  : true when one more FIFO read cannot overflow the 2-entry output buffer
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PKT_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    // Words already owned by the reader (buffered + in flight) after this cycle's pop.
    // A new read is allowed only while that total is below the buffer depth of 2.
    // pop is only ever 1 when occ is non-zero, so the subtraction cannot underflow.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] used;
        used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (used < 3'd2);
    endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order output buffer for the stream reader.
// Ports:
//  clk, rst          clock / asynchronous active-low reset
//  push_i, push_data_i  write a word at the tail
//  pop_i             remove the head word (ignored when empty)
//  head_data_o       current head word (zero after reset)
//  occ_o             number of stored words, 0..2
module stream_skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q,  occ_d;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Next-state for the two storage slots; head always holds the oldest word.
    always_comb begin
        pop_ok_s  = pop_i & (occ_q != 2'd0);
        push_ok_s = push_i & ((occ_q != 2'd2) | pop_ok_s);
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the older stored word (if any) moves to the head.
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data_o = head_q;
    assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the 16x8 synchronous FIFO: pulls words through the FIFO's
// registered read port and presents them as a valid/ready stream with packet framing.
// Ports:
//  clk, rst      clock / asynchronous active-low reset
//  enable        1 = fetch from the FIFO, 0 = stop fetching and drain
//  fifo_empty    FIFO empty flag
//  fifo_rd_en    FIFO read request (combinational)
//  fifo_rd_data  FIFO read data, valid the cycle after an accepted read
//  m_valid, m_data, m_last, m_ready   output stream with end-of-packet marker
//  pkt_cnt       completed packets, wraps
//  busy          reader not idle
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              busy
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    rd_state_e         state_q, state_d;
    logic              inflight_q;
    logic [7:0]        beat_q, beat_d;
    logic [CNT_W-1:0]  pkt_q, pkt_d;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] head_s;
    logic              valid_s;
    logic              pop_s;
    logic              rd_en_s;
    logic              at_last_s;

    assign valid_s   = (occ_s != 2'd0);
    assign pop_s     = valid_s & m_ready;
    assign at_last_s = (beat_q == LAST_BEAT);
    assign rd_en_s   = (state_q == ST_RUN) & enable & ~fifo_empty & credit_ok(occ_s, inflight_q, pop_s);

    // The word read last cycle arrives now and is pushed straight into the buffer.
    stream_skid_buf2 #(
        .W (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop_s),
        .head_data_o (head_s),
        .occ_o       (occ_s)
    );

    // Reader FSM next state; DRAIN waits for every owned word to leave before idling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if ((occ_s == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Packet framing: beat position and completed-packet count advance on each accepted beat.
    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop_s) begin
            if (at_last_s) begin
                beat_d = 8'd0;
                pkt_d  = pkt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // State, in-flight flag and framing counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            beat_q     <= 8'd0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en_s;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_data     = head_s;
    assign m_last     = valid_s & at_last_s;
    assign pkt_cnt    = pkt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
